// File: rtl/nv_nvdla_hls_sat_arb.sv
// ---------------------------------------------------------------------------
// nv_nvdla_hls_sat_arb
//
// Two-requester round-robin arbiter feeding one shared saturation stage and
// one output register. The winning requester's signed IN_WIDTH-bit word is
// clamped to the signed OUT_WIDTH-bit range. It is then held in a single-entry
// output pipe with a valid/ready handshake. A 16-bit sticky counter per
// requester counts how many of its accepted words were clamped.
//
// Parameters
//   IN_WIDTH   signed input word width (must exceed OUT_WIDTH)
//   OUT_WIDTH  signed saturated output width
//
// Ports
//   nvdla_core_clk        clock
//   nvdla_core_rst        synchronous active-high reset
//   req0_pvld/prdy/pd     requester 0 valid / accept / signed data
//   req1_pvld/prdy/pd     requester 1 valid / accept / signed data
//   dout_pvld/prdy/pd     output valid / downstream accept / saturated data
//   dout_src              requester that produced dout_pd
//   dout_sat              dout_pd was clamped
//   cnt_clr               clear both saturation counters
//   sat_cnt0/sat_cnt1     saturating clamp-event counters per requester
// ---------------------------------------------------------------------------
module nv_nvdla_hls_sat_arb #(
  parameter int IN_WIDTH  = 49,
  parameter int OUT_WIDTH = 32
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        req0_pvld,
  output logic                        req0_prdy,
  input  logic signed [IN_WIDTH-1:0]  req0_pd,
  input  logic                        req1_pvld,
  output logic                        req1_prdy,
  input  logic signed [IN_WIDTH-1:0]  req1_pd,
  output logic                        dout_pvld,
  input  logic                        dout_prdy,
  output logic signed [OUT_WIDTH-1:0] dout_pd,
  output logic                        dout_src,
  output logic                        dout_sat,
  input  logic                        cnt_clr,
  output logic [15:0]                 sat_cnt0,
  output logic [15:0]                 sat_cnt1
);

  localparam int EXT_W = IN_WIDTH - OUT_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pipe_state_t;

  // True when the word carries magnitude beyond the output range: every bit
  // from IN_WIDTH-2 down to OUT_WIDTH-1 must replicate the sign bit.
  function automatic logic sat_detect(input logic signed [IN_WIDTH-1:0] pd);
    logic [EXT_W-1:0] ext;
    ext = pd[IN_WIDTH-2:OUT_WIDTH-1];
    return (ext != {EXT_W{pd[IN_WIDTH-1]}});
  endfunction

  // Clamp to the most positive / most negative OUT_WIDTH value, or truncate
  // when the word already fits.
  function automatic logic signed [OUT_WIDTH-1:0] sat_value(
    input logic signed [IN_WIDTH-1:0] pd
  );
    if (!sat_detect(pd)) begin
      return $signed(pd[OUT_WIDTH-1:0]);
    end else if (pd[IN_WIDTH-1]) begin
      return $signed({1'b1, {(OUT_WIDTH-1){1'b0}}});
    end else begin
      return $signed({1'b0, {(OUT_WIDTH-1){1'b1}}});
    end
  endfunction

  // Sticky 16-bit event counter; clear wins over a same-cycle increment.
  function automatic logic [15:0] cnt_next(
    input logic [15:0] cur,
    input logic        inc,
    input logic        clr
  );
    if (clr) begin
      return 16'd0;
    end else if (inc && (cur != 16'hFFFF)) begin
      return cur + 16'd1;
    end else begin
      return cur;
    end
  endfunction

  pipe_state_t                 state_p1;
  pipe_state_t                 state_nxt;
  logic                        ptr_p1;
  logic                        ptr_nxt;
  logic                        open_p0;
  logic                        gnt0_p0;
  logic                        gnt1_p0;
  logic                        vld_p0;
  logic signed [IN_WIDTH-1:0]  pd_p0;
  logic signed [OUT_WIDTH-1:0] sat_pd_p0;
  logic                        sat_p0;
  logic signed [OUT_WIDTH-1:0] dout_pd_p1;
  logic                        dout_src_p1;
  logic                        dout_sat_p1;
  logic [15:0]                 cnt0_p1;
  logic [15:0]                 cnt1_p1;

  // ---- stage p0: arbitration and pipe control (combinational) ----
  // Grant looks only at valids, pointer, pipe occupancy and dout_prdy, so
  // there is no path from request data to the accept signals. Reset forces
  // both accepts low so nothing is taken while the pipe is being flushed.
  always_comb begin
    open_p0   = 1'b0;
    gnt0_p0   = 1'b0;
    gnt1_p0   = 1'b0;
    state_nxt = state_p1;
    ptr_nxt   = ptr_p1;
    if (!nvdla_core_rst) begin
      open_p0 = (state_p1 == EMPTY) || dout_prdy;
      if (open_p0) begin
        if (req0_pvld && (!req1_pvld || !ptr_p1)) begin
          gnt0_p0 = 1'b1;
        end else if (req1_pvld) begin
          gnt1_p0 = 1'b1;
        end
      end
    end
    vld_p0 = gnt0_p0 || gnt1_p0;
    if (vld_p0) begin
      state_nxt = FULL;
      // Prefer the requester that lost (or was idle) on the next cycle.
      ptr_nxt   = gnt0_p0;
    end else if ((state_p1 == FULL) && dout_prdy) begin
      state_nxt = EMPTY;
    end
  end

  assign pd_p0     = gnt1_p0 ? req1_pd : req0_pd;
  assign sat_p0    = sat_detect(pd_p0);
  assign sat_pd_p0 = sat_value(pd_p0);

  // ---- stage p1: output register, pointer and counters ----
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_p1    <= EMPTY;
      ptr_p1      <= 1'b0;
      dout_pd_p1  <= '0;
      dout_src_p1 <= 1'b0;
      dout_sat_p1 <= 1'b0;
      cnt0_p1     <= 16'd0;
      cnt1_p1     <= 16'd0;
    end else begin
      state_p1 <= state_nxt;
      ptr_p1   <= ptr_nxt;
      if (vld_p0) begin
        dout_pd_p1  <= sat_pd_p0;
        dout_src_p1 <= gnt1_p0;
        dout_sat_p1 <= sat_p0;
      end
      cnt0_p1 <= cnt_next(cnt0_p1, gnt0_p0 && sat_p0, cnt_clr);
      cnt1_p1 <= cnt_next(cnt1_p1, gnt1_p0 && sat_p0, cnt_clr);
    end
  end

  assign req0_prdy = gnt0_p0;
  assign req1_prdy = gnt1_p0;
  assign dout_pvld = (state_p1 == FULL);
  assign dout_pd   = dout_pd_p1;
  assign dout_src  = dout_src_p1;
  assign dout_sat  = dout_sat_p1;
  assign sat_cnt0  = cnt0_p1;
  assign sat_cnt1  = cnt1_p1;

  a_one_grant : assert property (
    @(posedge nvdla_core_clk) !(req0_prdy && req1_prdy)
  );

  a_hold_stable : assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    (dout_pvld && !dout_prdy) |=>
      ($stable(dout_pd) && $stable(dout_src) && $stable(dout_sat) && dout_pvld)
  );

endmodule

// File: tb/tb_nv_nvdla_hls_sat_arb.sv
module tb_nv_nvdla_hls_sat_arb;

  localparam logic [48:0] P1234 = 49'h0_0000_0000_1234;
  localparam logic [48:0] POSB  = 49'h0_0001_0000_0000;
  localparam logic [48:0] NEGB  = 49'h1_FFFE_FFFF_FFFF;
  localparam logic [48:0] NEG1  = 49'h1_FFFF_FFFF_FFFF;
  localparam logic [48:0] P7F   = 49'h0_0000_7FFF_FFFF;
  localparam logic [48:0] P80   = 49'h0_0000_8000_0000;
  localparam logic [48:0] N80   = 49'h1_FFFF_8000_0000;
  localparam logic [48:0] N7F   = 49'h1_FFFF_7FFF_FFFF;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_pvld = 1'b0;
  logic        req0_prdy;
  logic [48:0] req0_pd = '0;
  logic        req1_pvld = 1'b0;
  logic        req1_prdy;
  logic [48:0] req1_pd = '0;
  logic        dout_pvld;
  logic        dout_prdy = 1'b0;
  logic [31:0] dout_pd;
  logic        dout_src;
  logic        dout_sat;
  logic        cnt_clr = 1'b0;
  logic [15:0] sat_cnt0;
  logic [15:0] sat_cnt1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, clr, v0;
    logic [48:0] pd0;
    logic        v1;
    logic [48:0] pd1;
    logic        dprdy;
    logic        e_rdy0, e_rdy1, e_vld, chk_d;
    logic [31:0] e_pd;
    logic        e_src, e_sat;
    logic [15:0] e_c0, e_c1;
  } vec_t;

  vec_t vecs[NV];

  nv_nvdla_hls_sat_arb #(.IN_WIDTH(49), .OUT_WIDTH(32)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .req0_pvld      (req0_pvld),
    .req0_prdy      (req0_prdy),
    .req0_pd        (req0_pd),
    .req1_pvld      (req1_pvld),
    .req1_prdy      (req1_prdy),
    .req1_pd        (req1_pd),
    .dout_pvld      (dout_pvld),
    .dout_prdy      (dout_prdy),
    .dout_pd        (dout_pd),
    .dout_src       (dout_src),
    .dout_sat       (dout_sat),
    .cnt_clr        (cnt_clr),
    .sat_cnt0       (sat_cnt0),
    .sat_cnt1       (sat_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rs, input logic cl, input logic a0, input logic [48:0] d0,
    input logic a1, input logic [48:0] d1, input logic dp,
    input logic r0, input logic r1, input logic vl, input logic cd,
    input logic [31:0] pd, input logic sr, input logic st,
    input logic [15:0] c0, input logic [15:0] c1
  );
    vec_t v;
    v.rst = rs; v.clr = cl; v.v0 = a0; v.pd0 = d0; v.v1 = a1; v.pd1 = d1;
    v.dprdy = dp; v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_vld = vl; v.chk_d = cd;
    v.e_pd = pd; v.e_src = sr; v.e_sat = st; v.e_c0 = c0; v.e_c1 = c1;
    return v;
  endfunction

  initial begin
    //          rst clr v0 pd0    v1 pd1    dp  r0 r1 vld cd pd            src sat c0 c1
    vecs[0]  = mk(1, 0, 1, P1234, 1, P1234, 1,  0, 0, 0, 1, 32'h0,        0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, P1234, 0, '0,    1,  1, 0, 1, 1, 32'h0000_1234, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, '0,    1, POSB,  1,  0, 1, 1, 1, 32'h7FFF_FFFF, 1, 1, 0, 1);
    vecs[3]  = mk(0, 0, 0, '0,    1, NEGB,  1,  0, 1, 1, 1, 32'h8000_0000, 1, 1, 0, 2);
    vecs[4]  = mk(0, 0, 0, '0,    1, NEG1,  1,  0, 1, 1, 1, 32'hFFFF_FFFF, 1, 0, 0, 2);
    vecs[5]  = mk(0, 0, 0, '0,    0, '0,    1,  0, 0, 0, 0, 32'h0,        0, 0, 0, 2);
    vecs[6]  = mk(0, 0, 1, P7F,   1, P80,   1,  1, 0, 1, 1, 32'h7FFF_FFFF, 0, 0, 0, 2);
    vecs[7]  = mk(0, 0, 1, P7F,   1, P80,   1,  0, 1, 1, 1, 32'h7FFF_FFFF, 1, 1, 0, 3);
    vecs[8]  = mk(0, 0, 1, N80,   1, N7F,   1,  1, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 3);
    vecs[9]  = mk(0, 0, 1, N80,   1, N7F,   1,  0, 1, 1, 1, 32'h8000_0000, 1, 1, 0, 4);
    for (int k = 10; k < 15; k++)
      vecs[k] = mk(0, 0, 1, P1234, 1, POSB, 0,  0, 0, 1, 1, 32'h8000_0000, 1, 1, 0, 4);
    vecs[15] = mk(0, 0, 1, P1234, 1, POSB,  1,  1, 0, 1, 1, 32'h0000_1234, 0, 0, 0, 4);
    vecs[16] = mk(0, 0, 1, P1234, 1, POSB,  1,  0, 1, 1, 1, 32'h7FFF_FFFF, 1, 1, 0, 5);
    vecs[17] = mk(0, 1, 1, POSB,  0, '0,    1,  1, 0, 1, 1, 32'h7FFF_FFFF, 0, 1, 0, 0);
    vecs[18] = mk(0, 0, 1, POSB,  0, '0,    1,  1, 0, 1, 1, 32'h7FFF_FFFF, 0, 1, 1, 0);
    vecs[19] = mk(1, 0, 1, P1234, 1, POSB,  0,  0, 0, 0, 1, 32'h0,        0, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, P1234, 1, NEG1,  0,  1, 0, 1, 1, 32'h0000_1234, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; cnt_clr = vecs[i].clr;
      req0_pvld = vecs[i].v0; req0_pd = vecs[i].pd0;
      req1_pvld = vecs[i].v1; req1_pd = vecs[i].pd1;
      dout_prdy = vecs[i].dprdy;
      #1;
      chk($sformatf("v%0d_req0_prdy", i), 64'(req0_prdy), 64'(vecs[i].e_rdy0));
      chk($sformatf("v%0d_req1_prdy", i), 64'(req1_prdy), 64'(vecs[i].e_rdy1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dout_pvld", i), 64'(dout_pvld), 64'(vecs[i].e_vld));
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d_dout_pd", i),  64'(dout_pd),  64'(vecs[i].e_pd));
        chk($sformatf("v%0d_dout_src", i), 64'(dout_src), 64'(vecs[i].e_src));
        chk($sformatf("v%0d_dout_sat", i), 64'(dout_sat), 64'(vecs[i].e_sat));
      end
      chk($sformatf("v%0d_sat_cnt0", i), 64'(sat_cnt0), 64'(vecs[i].e_c0));
      chk($sformatf("v%0d_sat_cnt1", i), 64'(sat_cnt1), 64'(vecs[i].e_c1));
    end

    // Fairness straight out of reset: both valid, downstream always ready.
    @(negedge clk);
    rst = 1'b1; cnt_clr = 1'b0; dout_prdy = 1'b1;
    req0_pvld = 1'b1; req1_pvld = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0_pd = P1234; req1_pd = NEG1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d_pvld", k), 64'(dout_pvld), 64'(1));
      chk($sformatf("fair%0d_src", k), 64'(dout_src), 64'(k % 2));
      chk($sformatf("fair%0d_pd", k), 64'(dout_pd),
          (k % 2 == 0) ? 64'h0000_1234 : 64'hFFFF_FFFF);
    end

    // Counter ceiling: one clamped req0 transfer per cycle.
    @(negedge clk);
    rst = 1'b1; req1_pvld = 1'b0;
    @(negedge clk);
    rst = 1'b0; req0_pvld = 1'b1; req0_pd = POSB;
    for (int i = 0; i < 65538; i++) begin
      @(posedge clk);
      #1;
      if (i == 0)     chk("cnt0_first", 64'(sat_cnt0), 64'(1));
      if (i == 65533) chk("cnt0_near",  64'(sat_cnt0), 64'(16'hFFFE));
      if (i == 65534) chk("cnt0_limit", 64'(sat_cnt0), 64'(16'hFFFF));
    end
    chk("cnt0_hold", 64'(sat_cnt0), 64'(16'hFFFF));
    chk("cnt1_idle", 64'(sat_cnt1), 64'(0));
    @(negedge clk);
    cnt_clr = 1'b1;
    #1;
    chk("clr_xfer_prdy", 64'(req0_prdy), 64'(1));
    @(posedge clk);
    #1;
    chk("clr_cnt0", 64'(sat_cnt0), 64'(0));
    chk("clr_dout_sat", 64'(dout_sat), 64'(1));
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("after_clr_cnt0", 64'(sat_cnt0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
